squash_redirect_ctrl: RTL and testbench

Sequencer between the level-1 squash arbiter and the fetch unit. It takes the single granted squash notification per cycle and keeps only the oldest outstanding one. It delivers that squash to fetch as a redirect over a val/rdy handshake. After each delivered redirect it enforces a settle window, during which stale (younger) squashes are discarded.

---
 rtl/squash_redirect_ctrl_pkg.sv | 21 ++
 rtl/squash_redirect_ctrl_if.sv | 26 ++
 rtl/squash_redirect_ctrl_age.sv | 35 +++
 rtl/squash_redirect_ctrl.sv | 155 +++++++++++++++
 tb/tb_squash_redirect_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/squash_redirect_ctrl_pkg.sv
// Shared types for the squash-to-fetch redirect sequencer.
// Holds the FSM state enum, widths and a saturating counter helper.
package squash_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    SETTLE
  } state_t;

  localparam int unsigned TARGET_W = 32;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned PERF_W   = 32;

  function automatic logic [PERF_W-1:0] sat_inc(
    input logic [PERF_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/squash_redirect_ctrl_if.sv
// Notification interfaces feeding the redirect sequencer.
// squash: val/seq_num/target (no backpressure); commit: full commit record.
interface squash_notif_if #(
  parameter int unsigned p_seq_num_bits = 5
);
  logic                      val;
  logic [p_seq_num_bits-1:0] seq_num;
  logic [31:0]               target;

  modport pub (output val, seq_num, target);
  modport sub (input  val, seq_num, target);
endinterface

interface commit_notif_if #(
  parameter int unsigned p_seq_num_bits = 5
);
  logic                      val;
  logic [31:0]               pc;
  logic [p_seq_num_bits-1:0] seq_num;
  logic [4:0]                waddr;
  logic [31:0]               wdata;
  logic                      wen;

  modport pub (output val, pc, seq_num, waddr, wdata, wen);
  modport sub (input  val, pc, seq_num, waddr, wdata, wen);
endinterface

// File: rtl/squash_redirect_ctrl_age.sv
// Tracks the last committed seq_num and answers is_older(a, b).
// Ports: clk, rst, commit_val/commit_seq in; a, b in; older out.
module squash_redirect_ctrl_age #(
  parameter int unsigned p_seq_num_bits = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      commit_val,
  input  logic [p_seq_num_bits-1:0] commit_seq,
  input  logic [p_seq_num_bits-1:0] a,
  input  logic [p_seq_num_bits-1:0] b,
  output logic                      older
);

  localparam logic [p_seq_num_bits-1:0] ONE =
    {{(p_seq_num_bits-1){1'b0}}, 1'b1};

  logic [p_seq_num_bits-1:0] last_commit;
  logic [p_seq_num_bits-1:0] age_a;
  logic [p_seq_num_bits-1:0] age_b;

  // Distance from the oldest in-flight slot; wraps naturally.
  assign age_a = a - last_commit - ONE;
  assign age_b = b - last_commit - ONE;
  assign older = age_a < age_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_commit <= '1;
    end else if (commit_val) begin
      last_commit <= commit_seq;
    end
  end

endmodule

// File: rtl/squash_redirect_ctrl.sv
// Keeps the oldest outstanding squash and delivers it to fetch as a redirect.
// Ports: squash/commit notif (sub), redirect val/rdy/target/seq_num.
// Optional perf counters when SQUASH_REDIRECT_CTRL_PERF_EN is defined.
module squash_redirect_ctrl
  import squash_redirect_ctrl_pkg::*;
#(
  parameter int unsigned p_seq_num_bits  = 5,
  parameter int unsigned p_settle_cycles = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  squash_notif_if.sub               squash,
  commit_notif_if.sub               commit,
  output logic                      redirect_val,
  input  logic                      redirect_rdy,
  output logic [TARGET_W-1:0]       redirect_target,
  output logic [p_seq_num_bits-1:0] redirect_seq_num
`ifdef SQUASH_REDIRECT_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0]         perf_accepted,
  output logic [PERF_W-1:0]         perf_replaced,
  output logic [PERF_W-1:0]         perf_dropped
`endif
);

  typedef struct packed {
    logic [p_seq_num_bits-1:0] seq_num;
    logic [TARGET_W-1:0]       target;
  } t_pending;

  localparam logic [CNT_W-1:0] SETTLE_LOAD =
    CNT_W'(p_settle_cycles - 1);

  state_t                    state;
  t_pending                  pend;
  t_pending                  in;
  logic [p_seq_num_bits-1:0] issued_seq;
  logic [CNT_W-1:0]          cnt;
  logic [p_seq_num_bits-1:0] cmp_b;
  logic                      older;
  logic                      in_older;

  assign in.seq_num = squash.seq_num;
  assign in.target  = squash.target;

  // One comparator: SETTLE checks against the delivered redirect,
  // PEND against the one still waiting.
  assign cmp_b    = (state == SETTLE) ? issued_seq : pend.seq_num;
  assign in_older = squash.val & older;

  squash_redirect_ctrl_age #(
    .p_seq_num_bits(p_seq_num_bits)
  ) u_age (
    .clk        (clk),
    .rst        (rst),
    .commit_val (commit.val),
    .commit_seq (commit.seq_num),
    .a          (squash.seq_num),
    .b          (cmp_b),
    .older      (older)
  );

  assign redirect_target  = pend.target;
  assign redirect_seq_num = pend.seq_num;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pend         <= '0;
      issued_seq   <= '0;
      cnt          <= '0;
      redirect_val <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (squash.val) begin
            pend         <= in;
            state        <= PEND;
            redirect_val <= 1'b1;
          end
        end
        PEND: begin
          if (in_older) begin
            pend <= in;
          end
          if (redirect_rdy) begin
            issued_seq <= pend.seq_num;
            cnt        <= SETTLE_LOAD;
            // An older squash arriving with the handshake keeps us pending.
            if (!in_older) begin
              state        <= SETTLE;
              redirect_val <= 1'b0;
            end
          end
        end
        SETTLE: begin
          if (in_older) begin
            pend         <= in;
            state        <= PEND;
            redirect_val <= 1'b1;
          end else if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          redirect_val <= 1'b0;
        end
      endcase
    end
  end

`ifdef SQUASH_REDIRECT_CTRL_PERF_EN
  logic ev_acc;
  logic ev_rep;
  logic ev_drop;

  assign ev_acc  = squash.val &
                   ((state == IDLE) | ((state == SETTLE) & older));
  assign ev_rep  = (state == PEND) & in_older;
  assign ev_drop = squash.val & ~older &
                   ((state == PEND) | (state == SETTLE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_accepted <= '0;
      perf_replaced <= '0;
      perf_dropped  <= '0;
    end else begin
      if (ev_acc)  perf_accepted <= sat_inc(perf_accepted);
      if (ev_rep)  perf_replaced <= sat_inc(perf_replaced);
      if (ev_drop) perf_dropped  <= sat_inc(perf_dropped);
    end
  end
`endif

  function automatic string trace(input int level);
    string st;
    string hs;
    unique case (state)
      IDLE:    st = "I";
      PEND:    st = "P";
      SETTLE:  st = "S";
      default: st = "?";
    endcase
    hs = (redirect_val && redirect_rdy) ? "*" : " ";
    if (level > 0) begin
      return $sformatf("%s:%0d%s c%0d", st, pend.seq_num, hs, cnt);
    end
    return $sformatf("%s:%0d%s", st, pend.seq_num, hs);
  endfunction

endmodule

// File: tb/tb_squash_redirect_ctrl.sv
// Self-checking bench for squash_redirect_ctrl.
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_squash_redirect_ctrl;

  localparam int W = 5;
  localparam int P = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         rdy;
  logic         rv;
  logic [31:0]  rt;
  logic [W-1:0] rs;
`ifdef SQUASH_REDIRECT_CTRL_PERF_EN
  logic [31:0]  pa, pr, pd;
`endif

  squash_notif_if #(.p_seq_num_bits(W)) sq ();
  commit_notif_if #(.p_seq_num_bits(W)) cm ();

  squash_redirect_ctrl #(
    .p_seq_num_bits(W),
    .p_settle_cycles(P)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .squash           (sq),
    .commit           (cm),
    .redirect_val     (rv),
    .redirect_rdy     (rdy),
    .redirect_target  (rt),
    .redirect_seq_num (rs)
`ifdef SQUASH_REDIRECT_CTRL_PERF_EN
    ,
    .perf_accepted    (pa),
    .perf_replaced    (pr),
    .perf_dropped     (pd)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: one optional pending redirect, plus a count of
  // remaining stale-filter cycles after each delivery.
  bit          m_pend;
  int          m_seq;
  logic [31:0] m_tgt;
  int          m_settle;
  int          m_issued;
  int          m_lc;

  function automatic int age(input int x);
    return (x - m_lc - 1) & ((1 << W) - 1);
  endfunction

  task automatic model_reset();
    m_pend = 0; m_seq = 0; m_tgt = 0;
    m_settle = 0; m_issued = 0; m_lc = (1 << W) - 1;
  endtask

  task automatic model_step();
    int s;
    bit sv, hs, old;
    s  = int'(sq.seq_num);
    sv = sq.val;
    if (m_pend) begin
      hs  = rdy;
      old = sv && (age(s) < age(m_seq));
      if (hs) begin
        m_issued = m_seq;
        m_settle = P;
      end
      if (old) begin
        m_seq = s; m_tgt = sq.target;
      end else if (hs) begin
        m_pend = 0;
      end
    end else if (m_settle > 0) begin
      if (sv && (age(s) < age(m_issued))) begin
        m_pend = 1; m_seq = s; m_tgt = sq.target; m_settle = 0;
      end else begin
        m_settle--;
      end
    end else if (sv) begin
      m_pend = 1; m_seq = s; m_tgt = sq.target;
    end
    if (cm.val) m_lc = int'(cm.seq_num);
  endtask

  task automatic drive(input bit sv, input logic [W-1:0] s,
                       input logic [31:0] t, input bit cv,
                       input logic [W-1:0] cs, input bit r);
    sq.val = sv; sq.seq_num = s; sq.target = t;
    cm.val = cv; cm.seq_num = cs;
    rdy = r;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    model_reset();
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (rv !== 1'b0 || rt !== 32'h0 || rs !== '0) begin
      errors++;
      $display("FAIL reset: val=%b tgt=%h seq=%0d want 0/0/0", rv, rt, rs);
    end
    tick();
    checks++;
    if (rv !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: val=%b want 0", rv);
    end
  endtask

  task automatic test_single();
    do_reset();
    drive(1, 3, 32'h1000, 0, 0, 1);
    tick();
    checks++;
    if (rv !== 1'b1 || rs !== 5'd3 || rt !== 32'h1000) begin
      errors++;
      $display("FAIL single_redirect: val=%b seq=%0d tgt=%h want 1/3/1000",
               rv, rs, rt);
    end
    drive(0, 0, 0, 0, 0, 1);
    tick();
    checks++;
    if (rv !== 1'b0) begin
      errors++;
      $display("FAIL single_handshake: val=%b want 0", rv);
    end
    tick();
    drive(1, 20, 32'h2000, 0, 0, 0);
    tick();
    checks++;
    if (rv !== 1'b0) begin
      errors++;
      $display("FAIL settle_second_cycle_drop: val=%b want 0", rv);
    end
    drive(1, 21, 32'h2100, 0, 0, 0);
    tick();
    checks++;
    if (rv !== 1'b1 || rs !== 5'd21) begin
      errors++;
      $display("FAIL idle_after_settle: val=%b seq=%0d want 1/21", rv, rs);
    end
  endtask

  task automatic test_replace_younger_settle();
    do_reset();
    drive(0, 0, 0, 1, 10, 0);
    tick();
    drive(1, 14, 32'h1400, 0, 0, 0);
    tick();
    checks++;
    if (rv !== 1'b1 || rs !== 5'd14) begin
      errors++;
      $display("FAIL replace_first: val=%b seq=%0d want 1/14", rv, rs);
    end
    drive(1, 12, 32'h1200, 0, 0, 0);
    tick();
    checks++;
    if (rs !== 5'd12 || rt !== 32'h1200) begin
      errors++;
      $display("FAIL replace_older: seq=%0d tgt=%h want 12/1200", rs, rt);
    end
    drive(1, 20, 32'h2000, 0, 0, 0);
    tick();
    checks++;
    if (rv !== 1'b1 || rs !== 5'd12 || rt !== 32'h1200) begin
      errors++;
      $display("FAIL younger_ignored: val=%b seq=%0d want 1/12", rv, rs);
    end
    drive(0, 0, 0, 0, 0, 1);
    tick();
    drive(1, 15, 32'h1500, 0, 0, 0);
    tick();
    checks++;
    if (rv !== 1'b0) begin
      errors++;
      $display("FAIL settle_drop_younger: val=%b want 0", rv);
    end
    drive(1, 11, 32'h1100, 0, 0, 0);
    tick();
    checks++;
    if (rv !== 1'b1 || rs !== 5'd11 || rt !== 32'h1100) begin
      errors++;
      $display("FAIL settle_capture_older: val=%b seq=%0d tgt=%h want 1/11/1100",
               rv, rs, rt);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(0, 0, 0, 1, 30, 0);
    tick();
    drive(1, 1, 32'h0100, 0, 0, 0);
    tick();
    checks++;
    if (rs !== 5'd1) begin
      errors++;
      $display("FAIL wrap_first: seq=%0d want 1", rs);
    end
    drive(1, 31, 32'h3100, 0, 0, 0);
    tick();
    checks++;
    if (rs !== 5'd31 || rt !== 32'h3100) begin
      errors++;
      $display("FAIL wrap_older: seq=%0d tgt=%h want 31/3100", rs, rt);
    end
  endtask

  task automatic test_commit_same_cycle();
    do_reset();
    drive(1, 5, 32'h0500, 0, 0, 0);
    tick();
    drive(1, 8, 32'h0800, 1, 6, 0);
    tick();
    checks++;
    if (rs !== 5'd5) begin
      errors++;
      $display("FAIL compare_before_commit: seq=%0d want 5", rs);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1, 5, 32'h0500, 0, 0, 0);
    tick();
    drive(1, 2, 32'h0200, 0, 0, 1);
    tick();
    checks++;
    if (rv !== 1'b1 || rs !== 5'd2 || rt !== 32'h0200) begin
      errors++;
      $display("FAIL hs_with_older: val=%b seq=%0d want 1/2", rv, rs);
    end
    drive(0, 0, 0, 0, 0, 1);
    tick();
    checks++;
    if (rv !== 1'b0) begin
      errors++;
      $display("FAIL hs_second: val=%b want 0", rv);
    end
    drive(1, 4, 32'h0400, 0, 0, 0);
    tick();
    checks++;
    if (rv !== 1'b0) begin
      errors++;
      $display("FAIL settle_vs_new_issued: val=%b want 0", rv);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1, 7, 32'h0700, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (rv !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: val=%b want 0", rv);
    end
    #1;
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (rv !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: val=%b want 0", rv);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(1, 0) == 1, W'($urandom),
            $urandom, $urandom_range(3, 0) == 0, W'($urandom),
            $urandom_range(4, 0) < 2);
      tick();
      checks++;
      if (rv !== m_pend ||
          (m_pend && (rs !== W'(m_seq) || rt !== m_tgt))) begin
        errors++;
        $display("FAIL random[%0d]: val=%b seq=%0d tgt=%h want %b/%0d/%h",
                 i, rv, rs, rt, m_pend, m_seq, m_tgt);
      end
    end
  endtask

  initial begin
    cm.pc = '0; cm.waddr = '0; cm.wdata = '0; cm.wen = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_single();
    test_replace_younger_settle();
    test_wrap();
    test_commit_same_cycle();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
